// File: rtl/chunked_add_sequencer.sv
// Wide adder that reuses one CHUNK-bit adder stage over WIDTH/CHUNK cycles,
// least-significant chunk first, with valid/ready handshakes on both sides.
module chunked_add_sequencer #(
    parameter int WIDTH = 512,
    parameter int CHUNK = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             busy_o
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] sum_q;

    logic [CHUNK-1:0] chunkSum_d;
    logic             chunkCarry_d;
    logic [WIDTH-1:0] opANext_d;
    logic [WIDTH-1:0] opBNext_d;
    logic [WIDTH-1:0] sumNext_d;

    // The only adder in the design: CHUNK bits plus the carry held from the previous chunk.
    assign {chunkCarry_d, chunkSum_d} = {1'b0, opA_q[CHUNK-1:0]}
                                      + {1'b0, opB_q[CHUNK-1:0]}
                                      + {{CHUNK{1'b0}}, carry_q};

    generate
        if (NCH == 1) begin : g_single
            assign opANext_d = '0;
            assign opBNext_d = '0;
            assign sumNext_d = chunkSum_d;
        end else begin : g_multi
            assign opANext_d = {{CHUNK{1'b0}}, opA_q[WIDTH-1:CHUNK]};
            assign opBNext_d = {{CHUNK{1'b0}}, opB_q[WIDTH-1:CHUNK]};
            assign sumNext_d = {chunkSum_d, sum_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        opA_q   <= a_i;
                        opB_q   <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    opA_q   <= opANext_d;
                    opB_q   <= opBNext_d;
                    sum_q   <= sumNext_d;
                    carry_q <= chunkCarry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    // Last chunk: the accumulator now holds the whole sum.
                    if (cnt_q == LAST) begin
                        cout_q  <= chunkCarry_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;

endmodule
